beep_note_decoder: RTL and testbench
====================================

# beep_note_decoder

Receive-side counterpart of the melody buzzer player: watches a buzzer-style square wave and reports which of the eight scale notes (DO…DOO) is sounding. It synchronises the input, measures the period between rising edges, classifies it against per-note period parameters within a tolerance, and debounces the result before reporting. Sits beside the buzzer output, for loopback self-check on the board and as a decoding monitor in simulation.

## Interface
- CNT_W, 20, width of period counter and `period` output
- DO, 191_110, full period of DO in clk cycles (50 MHz)
- RE, 170_264; MI, 151_685; FA, 143_172; SO, 127_551; LA, 113_636; XI, 101_239; DOO, 95_556: full periods of the remaining notes
- TOL, 2_000, max absolute deviation |measured − note period| for a match
- TIMEOUT, 500_000, cycles without a rising edge before the input is declared silent
- STABLE, 2, consecutive equal classifications needed to report a note (≥1)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  decoder enable; low forces the silent state synchronously
- beep_in  in  1  asynchronous square wave from the buzzer path
- note  out  4  0 = none/silent, 1..8 = DO..DOO, 15 = unrecognised period
- note_valid  out  1  one-cycle pulse whenever `note` changes value
- silent  out  1  high while no tone is detected
- period  out  CNT_W  last measured period in clk cycles

## Operation
- Input: two-flop synchroniser, then a third flop for edge detect; rise = sync & ~prev.
- Counter `cnt`: cleared to 0 on rise, else +1, saturating at 2^CNT_W−1. Measured period on a rise = cnt + 1 (exact for a clean period-P wave).
- Classifier (combinational on measured period): first note in order DO..DOO with |meas − NOTE| ≤ TOL gives its code; no match gives 15. Compare at CNT_W+1 bits, no wrap.
- States:
  - SILENT: note=0, silent=1. Rise → ACQUIRE; no period is recorded (previous edge unknown).
  - ACQUIRE: on rise, load `period`, classify. If code == cand, match_cnt+1, else cand=code, match_cnt=1. When match_cnt reaches STABLE → LOCKED, note=cand, silent=0. `note` is held unchanged while in ACQUIRE.
  - LOCKED: on rise, load `period`, classify. Code == note → stay. Different → ACQUIRE with cand=code, match_cnt=1; note held.
- Timeout: in ACQUIRE or LOCKED, cnt reaching TIMEOUT−1 with no rise → SILENT, note=0, silent=1, cand/match_cnt cleared.
- note_valid pulses only when the registered `note` actually changes (including to 0 on timeout); relock to the same code gives no pulse.
- Code 15 is reportable like any note once stable.
- enable low: next clock → SILENT, note=0, silent=1, period=0, no note_valid pulse; counters cleared.

## Timing
- Reset (async, rst_n low): note=0, note_valid=0, silent=1, period=0, state SILENT, all counters and synchroniser flops 0.
- Rise detect latency: 2–3 clk after the input edge (synchroniser).
- `period`, `note`, `silent`, `note_valid` all registered; they update on the clock edge following the cycle in which rise is asserted.
- Clean tone from silence: note reported on the (STABLE+1)-th rising edge.
- Rise and timeout in the same cycle: rise wins.
- Rise and enable low in the same cycle: enable wins.
- rst_n asserted mid-lock: outputs go to reset values immediately, independent of clk.

## Test plan
Bench overrides: DO=190, RE=170, MI=151, FA=143, SO=127, LA=113, XI=101, DOO=95, TOL=3, TIMEOUT=500, STABLE=2, CNT_W=10; clk 20 ns.
- Reset → note=0, silent=1, note_valid=0, period=0 while rst_n low and after release with beep_in=0.
- 190-cycle square wave → on 3rd rise note=1, silent=0, period=190, exactly one note_valid pulse; no further pulses while tone continues.
- 153-cycle wave → note=3 (MI); 147-cycle wave (between FA+3 and MI−3) → note=15 after two edges.
- DO locked, switch to 127-cycle wave → note stays 1 through first SO edge, becomes 5 on second SO edge, one pulse; a single 113-cycle glitch period inside DO → note stays 1, no pulse.
- Stop toggling while DO locked → 500 cycles after the last rise note=0, silent=1, one note_valid pulse.
- enable=0 while locked → next cycle note=0, silent=1, period=0, no pulse; rst_n low mid-tone → outputs reset immediately without a clock edge.

Source files
------------

// File: rtl/beep_note_decoder.sv
// beep_note_decoder: watches a buzzer-style square wave, measures the period
// between rising edges, classifies it against the eight scale note periods
// (DO..DOO) and reports a note once it has been seen STABLE times in a row.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SILENT  | no tone; waiting for a first rising edge (no period known yet)
// ACQUIRE | collecting equal classifications; reported note is held
// LOCKED  | a note is reported; each new period is checked against it
module beep_note_decoder #(
   parameter int CNT_W   = 20,
   parameter int DO      = 191_110,
   parameter int RE      = 170_264,
   parameter int MI      = 151_685,
   parameter int FA      = 143_172,
   parameter int SO      = 127_551,
   parameter int LA      = 113_636,
   parameter int XI      = 101_239,
   parameter int DOO     = 95_556,
   parameter int TOL     = 2_000,
   parameter int TIMEOUT = 500_000,
   parameter int STABLE  = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             beep_in,
   output logic [3:0]       note,
   output logic             note_valid,
   output logic             silent,
   output logic [CNT_W-1:0] period
);

   localparam int MW = $clog2(STABLE + 1);
   localparam int NOTE_TAB [0:7] = '{DO, RE, MI, FA, SO, LA, XI, DOO};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]       CODE_UNK = 4'd15;

   typedef enum logic [1:0] {
      ST_SILENT  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_sync1, r_sync2, r_prev;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]       r_note, w_note_nxt;
   logic             r_silent, w_silent_nxt;
   logic             r_valid, w_valid_nxt;
   logic [CNT_W-1:0] r_period, w_period_nxt;
   logic [3:0]       r_cand, w_cand_nxt;
   logic [MW-1:0]    r_match, w_match_nxt;

   logic             w_rise;
   logic             w_timeout;
   logic [CNT_W:0]   w_meas;
   logic [3:0]       w_code;
   logic [MW-1:0]    w_match_inc;

   // First note in scale order within TOL of the measured period; 15 if none.
   // Arithmetic is one bit wider than the counter so nothing wraps.
   function automatic logic [3:0] classify(input logic [CNT_W:0] meas);
      logic [3:0]     code;
      logic [CNT_W:0] np;
      logic [CNT_W:0] diff;
      logic [CNT_W:0] tol;
      code = CODE_UNK;
      tol  = (CNT_W+1)'(TOL);
      for (int i = 0; i < 8; i++) begin
         np   = (CNT_W+1)'(NOTE_TAB[i]);
         diff = (meas >= np) ? (meas - np) : (np - meas);
         if (code == CODE_UNK && diff <= tol) begin
            code = 4'(i + 1);
         end
      end
      return code;
   endfunction

   // Two-flop synchroniser plus a history flop for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= beep_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_rise      = r_sync2 & ~r_prev;
   assign w_meas      = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_code      = classify(w_meas);
   assign w_timeout   = (r_cnt == CNT_TO);
   assign w_match_inc = (w_code == r_cand) ? (r_match + MW'(1)) : MW'(1);

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_SILENT;
         r_cnt    <= '0;
         r_note   <= 4'd0;
         r_silent <= 1'b1;
         r_valid  <= 1'b0;
         r_period <= '0;
         r_cand   <= 4'd0;
         r_match  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_note   <= w_note_nxt;
         r_silent <= w_silent_nxt;
         r_valid  <= w_valid_nxt;
         r_period <= w_period_nxt;
         r_cand   <= w_cand_nxt;
         r_match  <= w_match_nxt;
      end
   end

   // Next-state logic; enable overrides everything, a rise beats a timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_note_nxt   = r_note;
      w_silent_nxt = r_silent;
      w_period_nxt = r_period;
      w_cand_nxt   = r_cand;
      w_match_nxt  = r_match;
      w_valid_nxt  = 1'b0;
      if (w_rise) begin
         w_cnt_nxt = '0;
      end else if (r_cnt != CNT_MAX) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
         w_cnt_nxt = r_cnt;
      end

      if (!enable) begin
         w_state_nxt  = ST_SILENT;
         w_cnt_nxt    = '0;
         w_note_nxt   = 4'd0;
         w_silent_nxt = 1'b1;
         w_period_nxt = '0;
         w_cand_nxt   = 4'd0;
         w_match_nxt  = '0;
      end else begin
         case (r_state)
            ST_SILENT: begin
               if (w_rise) begin
                  w_state_nxt = ST_ACQUIRE;
                  w_cand_nxt  = 4'd0;
                  w_match_nxt = '0;
               end
            end
            ST_ACQUIRE: begin
               if (w_rise) begin
                  w_period_nxt = w_meas[CNT_W-1:0];
                  w_cand_nxt   = w_code;
                  w_match_nxt  = w_match_inc;
                  if (w_match_inc >= MW'(STABLE)) begin
                     w_state_nxt  = ST_LOCKED;
                     w_note_nxt   = w_code;
                     w_silent_nxt = 1'b0;
                  end
               end else if (w_timeout) begin
                  w_state_nxt  = ST_SILENT;
                  w_note_nxt   = 4'd0;
                  w_silent_nxt = 1'b1;
                  w_cand_nxt   = 4'd0;
                  w_match_nxt  = '0;
               end
            end
            ST_LOCKED: begin
               if (w_rise) begin
                  w_period_nxt = w_meas[CNT_W-1:0];
                  if (w_code != r_note) begin
                     w_cand_nxt  = w_code;
                     w_match_nxt = MW'(1);
                     // With STABLE of one a single differing period relocks.
                     if (STABLE <= 1) begin
                        w_note_nxt = w_code;
                     end else begin
                        w_state_nxt = ST_ACQUIRE;
                     end
                  end
               end else if (w_timeout) begin
                  w_state_nxt  = ST_SILENT;
                  w_note_nxt   = 4'd0;
                  w_silent_nxt = 1'b1;
                  w_cand_nxt   = 4'd0;
                  w_match_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = ST_SILENT;
            end
         endcase
         w_valid_nxt = (w_note_nxt != r_note);
      end
   end

   assign note       = r_note;
   assign note_valid = r_valid;
   assign silent     = r_silent;
   assign period     = r_period;

endmodule

// File: tb/tb_beep_note_decoder.sv
// Directed bench for beep_note_decoder with small note periods. Expected
// note_valid events are queued by the stimulus and popped by a monitor.
module tb_beep_note_decoder;

   localparam int CW = 10;

   typedef struct packed {
      logic [3:0]    note;
      logic          silent;
      logic [CW-1:0] period;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b1;
   logic          beep_in = 1'b0;
   logic [3:0]    note;
   logic          note_valid;
   logic          silent;
   logic [CW-1:0] period;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;

   beep_note_decoder #(
      .CNT_W(CW), .DO(190), .RE(170), .MI(151), .FA(143), .SO(127),
      .LA(113), .XI(101), .DOO(95), .TOL(3), .TIMEOUT(500), .STABLE(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .beep_in(beep_in),
      .note(note), .note_valid(note_valid), .silent(silent), .period(period)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // n full periods of p cycles, starting with a rising edge
   task automatic wave(input int p, input int n);
      for (int k = 0; k < n; k++) begin
         beep_in = 1'b1;
         repeat (p / 2) tick();
         beep_in = 1'b0;
         repeat (p - p / 2) tick();
      end
   endtask

   task automatic push(input int n, input int s, input int p);
      exp_t e;
      e.note   = 4'(n);
      e.silent = 1'(s);
      e.period = CW'(p);
      q.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && note_valid === 1'b1) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse: got note=%0d expected no pulse", note);
            end else begin
               e = q.pop_front();
               check("pulse_note", 32'(note), 32'(e.note));
               check("pulse_silent", 32'(silent), 32'(e.silent));
               check("pulse_period", 32'(period), 32'(e.period));
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_note"}, 32'(note), 0);
      check({tag, "_silent"}, 32'(silent), 1);
      check({tag, "_valid"}, 32'(note_valid), 0);
      check({tag, "_period"}, 32'(period), 0);
   endtask

   initial begin
      fork
         monitor();
      join_none

      repeat (3) tick();
      check_reset_outputs("rst_low");
      rst_n = 1'b1;
      repeat (3) tick();
      check_reset_outputs("rst_rel");

      push(1, 0, 190);
      wave(190, 6);
      check("do_note", 32'(note), 1);
      check("do_silent", 32'(silent), 0);
      check("do_period", 32'(period), 190);

      push(3, 0, 153);
      wave(153, 4);
      check("mi_note", 32'(note), 3);

      push(15, 0, 147);
      wave(147, 4);
      check("unk_note", 32'(note), 15);
      check("unk_silent", 32'(silent), 0);

      push(1, 0, 190);
      wave(190, 4);
      wave(127, 2);
      check("so_first_note", 32'(note), 1);
      check("so_first_period", 32'(period), 127);
      push(5, 0, 127);
      wave(127, 1);
      check("so_note", 32'(note), 5);

      push(1, 0, 190);
      wave(190, 3);
      wave(113, 1);
      wave(190, 1);
      check("glitch_note", 32'(note), 1);
      check("glitch_period", 32'(period), 113);
      wave(190, 2);
      check("relock_note", 32'(note), 1);
      check("relock_silent", 32'(silent), 0);

      push(0, 1, 190);
      repeat (300) tick();
      check("pre_timeout_note", 32'(note), 1);
      repeat (20) tick();
      check("timeout_note", 32'(note), 0);
      check("timeout_silent", 32'(silent), 1);

      push(1, 0, 190);
      wave(190, 4);
      check("en_locked_note", 32'(note), 1);
      enable = 1'b0;
      tick();
      check("dis_note", 32'(note), 0);
      check("dis_silent", 32'(silent), 1);
      check("dis_period", 32'(period), 0);
      check("dis_valid", 32'(note_valid), 0);
      repeat (5) tick();
      enable = 1'b1;
      tick();

      push(1, 0, 190);
      wave(190, 3);
      check("pre_arst_note", 32'(note), 1);
      beep_in = 1'b1;
      repeat (40) tick();
      #4;
      rst_n = 1'b0;
      #2;
      check_reset_outputs("arst");
      tick();
      beep_in = 1'b0;
      rst_n = 1'b1;
      repeat (5) tick();
      check("queue_empty", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
